// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through buffer of {error flags, data}
// with sticky overflow and RTS hysteresis. Define UART_RX_FIFO_OVERWRITE_EN to overwrite oldest on full.
module uart_rx_fifo #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int RTS_THRESHOLD = 6
) (
    input  logic                          SysClk,
    input  logic                          Rst,
    input  logic [DATA_BITS-1:0]          Wr_Data,
    input  logic [2:0]                    Wr_Error,
    input  logic                          Wr_Valid,
    input  logic                          Read_Done,
    input  logic                          Ovf_Clear,
    output logic [DATA_BITS-1:0]          Data_Out,
    output logic [2:0]                    Rx_Error,
    output logic                          Data_Rdy,
    output logic                          FIFO_Empty,
    output logic                          FIFO_Full,
    output logic                          FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          RTS
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RTS_HI   = CW'(RTS_THRESHOLD);
    localparam logic [CW-1:0] RTS_LO   = CW'(RTS_THRESHOLD - 2);

    typedef struct packed {
        logic [2:0]           err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        wr_entry, head_q, head_nxt;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          empty_q, full_q, ovf_q, rts_q;
    logic          is_empty, is_full, push, pop, adv_rd, ovf_evt, ovf_nxt, rts_nxt;

    always_comb begin
        wr_entry.err  = Wr_Error;
        wr_entry.data = Wr_Data;
        is_empty = (cnt == '0);
        is_full  = (cnt == FULL_CNT);
        pop      = Read_Done && !is_empty;
        ovf_evt  = Wr_Valid && is_full && !Read_Done;
`ifdef UART_RX_FIFO_OVERWRITE_EN
        push   = Wr_Valid;
        adv_rd = pop || ovf_evt;
`else
        push   = Wr_Valid && (!is_full || pop);
        adv_rd = pop;
`endif
        wr_nxt = push   ? wr_ptr + AW'(1) : wr_ptr;
        rd_nxt = adv_rd ? rd_ptr + AW'(1) : rd_ptr;

        cnt_nxt = cnt;
        if (push && !adv_rd)
            cnt_nxt = cnt + CW'(1);
        else if (!push && adv_rd)
            cnt_nxt = cnt - CW'(1);

        // Head after the edge: hold when going empty, bypass the incoming word
        // when it lands in an otherwise empty buffer, else read ahead from storage.
        if (cnt_nxt == '0)
            head_nxt = head_q;
        else if (push && (is_empty || (cnt == CW'(1) && pop)))
            head_nxt = wr_entry;
        else
            head_nxt = mem[rd_nxt];

        ovf_nxt = ovf_q;
        if (ovf_evt)
            ovf_nxt = 1'b1;
        else if (Ovf_Clear)
            ovf_nxt = 1'b0;

        rts_nxt = rts_q;
        if (cnt_nxt >= RTS_HI)
            rts_nxt = 1'b0;
        else if (cnt_nxt <= RTS_LO)
            rts_nxt = 1'b1;
    end

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rts_q   <= 1'b1;
            head_q  <= '0;
        end else begin
            rd_ptr  <= rd_nxt;
            wr_ptr  <= wr_nxt;
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == FULL_CNT);
            ovf_q   <= ovf_nxt;
            rts_q   <= rts_nxt;
            head_q  <= head_nxt;
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge SysClk) begin
        if (!Rst && push)
            mem[wr_ptr] <= wr_entry;
    end

    assign Data_Out      = head_q.data;
    assign Rx_Error      = head_q.err;
    assign Data_Rdy      = !empty_q;
    assign FIFO_Empty    = empty_q;
    assign FIFO_Full     = full_q;
    assign FIFO_Overflow = ovf_q;
    assign Count         = cnt;
    assign RTS           = rts_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int THR   = 6;

    logic       SysClk = 1'b0;
    logic       Rst = 1'b0;
    logic [7:0] Wr_Data = '0;
    logic [2:0] Wr_Error = '0;
    logic       Wr_Valid = 1'b0, Read_Done = 1'b0, Ovf_Clear = 1'b0;
    logic [7:0] Data_Out;
    logic [2:0] Rx_Error;
    logic       Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS;
    logic [3:0] Count;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of {err,data}, plus sticky flag, RTS and shown head
    logic [10:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_rts = 1'b1;
    logic [10:0] m_head = '0;

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .RTS_THRESHOLD(THR)) dut (
        .SysClk(SysClk), .Rst(Rst), .Wr_Data(Wr_Data), .Wr_Error(Wr_Error),
        .Wr_Valid(Wr_Valid), .Read_Done(Read_Done), .Ovf_Clear(Ovf_Clear),
        .Data_Out(Data_Out), .Rx_Error(Rx_Error), .Data_Rdy(Data_Rdy),
        .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full), .FIFO_Overflow(FIFO_Overflow),
        .Count(Count), .RTS(RTS)
    );

    always #5 SysClk = ~SysClk;

    // Drive one cycle of stimulus, advance the model, release strobes at edge+1.
    task automatic step(input logic wv, input logic [7:0] wd, input logic [2:0] we,
                        input logic rd, input logic oc, input logic rs);
        logic full, popped, set;
        Wr_Valid = wv; Wr_Data = wd; Wr_Error = we;
        Read_Done = rd; Ovf_Clear = oc; Rst = rs;
        @(posedge SysClk);
        if (rs) begin
            q.delete(); m_ovf = 1'b0; m_rts = 1'b1; m_head = '0;
        end else begin
            full   = (q.size() == DEPTH);
            popped = rd && (q.size() != 0);
            set    = 1'b0;
            if (popped) void'(q.pop_front());
            if (wv) begin
                if (!full || popped) q.push_back({we, wd});
                else begin
                    set = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
                    void'(q.pop_front());
                    q.push_back({we, wd});
`endif
                end
            end
            if (set) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
            if (q.size() >= THR) m_rts = 1'b0;
            else if (q.size() <= THR - 2) m_rts = 1'b1;
            if (q.size() != 0) m_head = q[0];
        end
        #1;
        Wr_Valid = 1'b0; Read_Done = 1'b0; Ovf_Clear = 1'b0; Rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b1);
        checks++; if (FIFO_Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", FIFO_Empty); end
        checks++; if (Data_Rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", Data_Rdy); end
        checks++; if (FIFO_Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", FIFO_Full); end
        checks++; if (FIFO_Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", FIFO_Overflow); end
        checks++; if (RTS !== 1'b1) begin failures++; $display("FAIL reset_rts got=%b exp=1", RTS); end
        checks++; if (Count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
        checks++; if ({Rx_Error, Data_Out} !== 11'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {Rx_Error, Data_Out}); end
    endtask

    task automatic test_basic();
        step(1'b1, 8'h11, 3'b000, 1'b0, 1'b0, 1'b0);
        checks++; if (Data_Out !== 8'h11 || Data_Rdy !== 1'b1) begin failures++; $display("FAIL basic_first got=%h rdy=%b exp=11 rdy=1", Data_Out, Data_Rdy); end
        step(1'b1, 8'h22, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 3'b000, 1'b0, 1'b0, 1'b0);
        checks++; if (Count !== 4'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", Count); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (Data_Out !== 8'h22) begin failures++; $display("FAIL basic_pop1 got=%h exp=22", Data_Out); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (Data_Out !== 8'h33) begin failures++; $display("FAIL basic_pop2 got=%h exp=33", Data_Out); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (FIFO_Empty !== 1'b1 || Count !== 4'd0 || Data_Out !== 8'h33) begin failures++; $display("FAIL basic_drain empty=%b cnt=%0d data=%h exp empty=1 cnt=0 data=33", FIFO_Empty, Count, Data_Out); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (Count !== 4'd0 || FIFO_Overflow !== 1'b0) begin failures++; $display("FAIL basic_pop_empty cnt=%0d ovf=%b exp 0 0", Count, FIFO_Overflow); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0, 1'b0);
        checks++; if (FIFO_Full !== 1'b1 || Count !== 4'd8) begin failures++; $display("FAIL ovf_full full=%b cnt=%0d exp 1 8", FIFO_Full, Count); end
        step(1'b1, 8'hAA, 3'b000, 1'b0, 1'b0, 1'b0);
        checks++; if (FIFO_Overflow !== 1'b1 || Count !== 4'd8) begin failures++; $display("FAIL ovf_set ovf=%b cnt=%0d exp 1 8", FIFO_Overflow, Count); end
        for (int i = 0; i < DEPTH; i++) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
            exp = (i == DEPTH - 1) ? 8'hAA : 8'(i + 1);
`else
            exp = 8'(i);
`endif
            checks++; if (Data_Out !== exp) begin failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, Data_Out, exp); end
            step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (FIFO_Overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", FIFO_Overflow); end
        step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
        checks++; if (FIFO_Overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", FIFO_Overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 8'h40), 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (FIFO_Overflow !== 1'b0 || Count !== 4'd8) begin failures++; $display("FAIL b2b_full ovf=%b cnt=%0d exp 0 8", FIFO_Overflow, Count); end
        checks++; if (Data_Out !== 8'h41) begin failures++; $display("FAIL b2b_head got=%h exp=41", Data_Out); end
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (Data_Out !== 8'h55 || Count !== 4'd1) begin failures++; $display("FAIL b2b_last got=%h cnt=%0d exp 55 1", Data_Out, Count); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (Count !== 4'd1 || Data_Out !== 8'h55 || Data_Rdy !== 1'b1) begin failures++; $display("FAIL b2b_empty cnt=%0d data=%h rdy=%b exp 1 55 1", Count, Data_Out, Data_Rdy); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_rts();
        for (int i = 1; i <= THR; i++) begin
            step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0, 1'b0);
            checks++; if (RTS !== (i < THR)) begin failures++; $display("FAIL rts_fill[%0d] got=%b exp=%b", i, RTS, (i < THR)); end
        end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (RTS !== 1'b0 || Count !== 4'd5) begin failures++; $display("FAIL rts_hold got=%b cnt=%0d exp 0 5", RTS, Count); end
        step(1'b1, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (RTS !== 1'b0) begin failures++; $display("FAIL rts_refall got=%b exp=0", RTS); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (RTS !== 1'b1 || Count !== 4'd4) begin failures++; $display("FAIL rts_release got=%b cnt=%0d exp 1 4", RTS, Count); end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_error_and_wrap();
        step(1'b1, 8'h3C, 3'b010, 1'b0, 1'b0, 1'b0);
        checks++; if (Rx_Error !== 3'b010 || Data_Out !== 8'h3C) begin failures++; $display("FAIL err_flags got=%b/%h exp=010/3c", Rx_Error, Data_Out); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            step(1'b1, 8'(i), 3'(i), 1'b1, 1'b0, 1'b0);
            checks++; if (Data_Out !== 8'(i) || Rx_Error !== 3'(i) || Count !== 4'd1) begin failures++; $display("FAIL wrap[%0d] got=%h/%b cnt=%0d exp=%h/%b 1", i, Data_Out, Rx_Error, Count, 8'(i), 3'(i)); end
        end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(i), 3'b001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
        checks++; if (Count !== 4'd5 || RTS !== 1'b0 || FIFO_Overflow !== 1'b1) begin failures++; $display("FAIL mid_pre cnt=%0d rts=%b ovf=%b exp 5 0 1", Count, RTS, FIFO_Overflow); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b1);
        checks++; if (FIFO_Empty !== 1'b1 || Count !== 4'd0 || RTS !== 1'b1 || FIFO_Overflow !== 1'b0) begin failures++; $display("FAIL mid_reset empty=%b cnt=%0d rts=%b ovf=%b exp 1 0 1 0", FIFO_Empty, Count, RTS, FIFO_Overflow); end
        step(1'b1, 8'h99, 3'b000, 1'b0, 1'b0, 1'b0);
        checks++; if (Count !== 4'd1 || Data_Out !== 8'h99) begin failures++; $display("FAIL mid_after cnt=%0d data=%h exp 1 99", Count, Data_Out); end
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic wv, rd, oc;
        int bias;
        step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            bias = ((n / 60) % 2 == 0) ? 75 : 25;
            wv = ($urandom_range(99) < bias);
            rd = ($urandom_range(99) < 100 - bias);
            oc = ($urandom_range(99) < 5);
            step(wv, 8'($urandom), 3'($urandom), rd, oc, 1'b0);
            checks++;
            if (Count !== 4'(q.size()) || FIFO_Empty !== (q.size() == 0) || Data_Rdy !== (q.size() != 0) ||
                FIFO_Full !== (q.size() == DEPTH) || FIFO_Overflow !== m_ovf || RTS !== m_rts ||
                {Rx_Error, Data_Out} !== m_head) begin
                failures++;
                $display("FAIL rand[%0d] got cnt=%0d e=%b f=%b o=%b rts=%b head=%h exp cnt=%0d o=%b rts=%b head=%h",
                         n, Count, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS, {Rx_Error, Data_Out},
                         q.size(), m_ovf, m_rts, m_head);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_rts();
        test_error_and_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver (bit-level deserializer) and the user/testbench read side of the UART interface. It captures each received word plus its 3-bit error flags. It presents the oldest entry first-word-fall-through on Data_Out/Rx_Error. It produces FIFO_Empty/FIFO_Full/FIFO_Overflow status and drives RTS hardware flow control with hysteresis.

Parameters:
DATA_BITS, 8, width of one received word
FIFO_DEPTH, 8, number of entries; power of two, >= 4
RTS_THRESHOLD, 6, occupancy at or above which RTS deasserts; 2 <= RTS_THRESHOLD <= FIFO_DEPTH

Ports:
SysClk  input  1  system clock, all logic on posedge
Rst  input  1  synchronous, active-high reset
Wr_Data  input  DATA_BITS  received word from receiver
Wr_Error  input  3  receiver error flags for Wr_Data ({parity, framing, break})
Wr_Valid  input  1  one-cycle strobe: Wr_Data/Wr_Error valid, push
Read_Done  input  1  one-cycle strobe: consumer finished with head entry, pop
Ovf_Clear  input  1  clears sticky FIFO_Overflow
Data_Out  output  DATA_BITS  head entry data
Rx_Error  output  3  head entry error flags
Data_Rdy  output  1  high when head entry valid (= !FIFO_Empty)
FIFO_Empty  output  1  occupancy == 0
FIFO_Full  output  1  occupancy == FIFO_DEPTH
FIFO_Overflow  output  1  sticky: a push was dropped
Count  output  $clog2(FIFO_DEPTH)+1  current occupancy
RTS  output  1  1 = ready to receive, 0 = remote must pause

Behaviour:
- Reset (Rst high at posedge): pointers and Count = 0; FIFO_Empty=1, Data_Rdy=0, FIFO_Full=0, FIFO_Overflow=0, RTS=1, Data_Out=0, Rx_Error=0. Storage contents are don't-care. Reset mid-operation discards all entries the same cycle.
- Storage: circular buffer of {Wr_Error, Wr_Data}. Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally at FIFO_DEPTH-1 -> 0. Count is kept as a separate register.
- Push: Wr_Valid=1 and not full -> entry written at write pointer; pointer++, Count++ at the same posedge.
- Pop: Read_Done=1 and not empty -> read pointer++, Count-- at the posedge.
- Latency: a push into an empty FIFO at edge N gives FIFO_Empty=0, Data_Rdy=1 and valid Data_Out/Rx_Error after edge N. A pop at edge N presents the next entry after edge N.
- All status outputs and Data_Out/Rx_Error are registered; no combinational path from inputs to outputs.
- Data_Out/Rx_Error hold the last popped value when empty. The consumer qualifies them with Data_Rdy.
- Simultaneous push+pop, neither empty nor full: both occur, Count unchanged.
- Simultaneous push+pop when full: pop frees a slot, push accepted, no overflow, Count stays FIFO_DEPTH.
- Simultaneous push+pop when empty: pop ignored, push accepted, Count=1.
- Pop while empty: ignored, no state change, no error flag.
- Push while full without pop: word dropped, contents unchanged, FIFO_Overflow set next cycle.
- FIFO_Overflow stays set until Ovf_Clear or Rst. If Ovf_Clear and a new overflow occur in the same cycle, set wins.
- RTS hysteresis, evaluated on the next-cycle Count:
  - RTS goes 0 when Count >= RTS_THRESHOLD.
  - RTS returns to 1 only when Count <= RTS_THRESHOLD-2.
  - Otherwise RTS holds its value.
- Pushes are still accepted while RTS=0, to absorb in-flight words.

Optional Feature:
UART_RX_FIFO_OVERWRITE_EN
- Defined: push while full without pop overwrites the oldest entry.
  - Read pointer and write pointer both advance; Count stays FIFO_DEPTH.
  - The new word becomes the newest entry; Data_Out shows the next-oldest after the edge.
  - FIFO_Overflow is still set (sticky).
- Undefined: the new word is dropped, as in Behaviour.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles -> Count=3, Data_Out=0x11 one cycle after first push. Three Read_Done pulses -> Data_Out 0x22, 0x33, then FIFO_Empty=1, Count=0.
- Fill 8 entries (0x00..0x07) -> FIFO_Full=1. Push 0xAA:
  - macro off: FIFO_Overflow=1, pops return 0x00..0x07.
  - macro on: pops return 0x01..0x07,0xAA.
  - Ovf_Clear -> FIFO_Overflow=0.
- Full FIFO, Wr_Valid=1 (0x55) and Read_Done=1 same cycle -> FIFO_Overflow stays 0, Count=8, last pop returns 0x55. Empty FIFO with the same pulse pair -> Count=1, Data_Out=0x55.
- RTS hysteresis with RTS_THRESHOLD=6: push to Count=6 -> RTS=0. Pop to Count=5 -> RTS stays 0. Pop to Count=4 -> RTS=1.
- Push 0x3C with Wr_Error=3'b010 -> Rx_Error=3'b010 alongside Data_Out=0x3C. Pointer wrap: 20 push/pop pairs (words 0..19) return data in order with no corruption.
- Count=5, RTS=0, Overflow=1, then Rst for one cycle -> next cycle FIFO_Empty=1, Count=0, RTS=1, FIFO_Overflow=0. A Read_Done during reset has no effect.
